// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit entry path.
package keypad_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } db_state_t;

  // Codes 10..15 from the encoder are treated the same as "no key".
  function automatic logic key_is_valid(input logic val_n, input logic [BCD_W-1:0] code);
    return (!val_n) && (code <= BCD_MAX);
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Press/release debouncer: emits a one-cycle accept with the latched code
// once a single valid key has been stable for DEBOUNCE_CYCLES samples.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] bcd_in,
  input  logic             data_val_n,
  output logic             accept,
  output logic [BCD_W-1:0] code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  db_state_t        state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [BCD_W-1:0] code_reg, code_next;
  logic             key_valid;

  assign key_valid = key_is_valid(data_val_n, bcd_in);
  assign code      = code_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      code_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (key_valid) begin
          state_next = PRESS_DB;
          code_next  = bcd_in;
          cnt_next   = CW'(1);
        end
      end
      PRESS_DB: begin
        // Once the count is reached the press is committed regardless of this sample.
        if (cnt_reg == CNT_DONE) begin
          accept     = 1'b1;
          state_next = HELD;
          cnt_next   = '0;
        end else if (!key_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (bcd_in != code_reg) begin
          code_next = bcd_in;
          cnt_next  = CW'(1);
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      HELD: begin
        if (!key_valid) begin
          state_next = REL_DB;
          cnt_next   = CW'(1);
        end
      end
      REL_DB: begin
        if (key_valid) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_DONE) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/keypad_digit_loader.sv
// Debounced BCD digit entry register with valid/ready hand-off.
// Define KEYPAD_ROLLOVER_EN to keep shifting (dropping the oldest digit) when full.
module keypad_digit_loader
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BCD_W-1:0]                  bcd_in,
  input  logic                              data_val_n,
  input  logic                              clear,
  input  logic                              start,
  input  logic                              load_ready,
  output logic [BCD_W*NUM_DIGITS-1:0]       digits_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              key_strobe,
  output logic                              load_valid
);

  localparam int DW    = BCD_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);

  logic             accept;
  logic [BCD_W-1:0] accept_code;
  logic [DW-1:0]    digits_reg, shifted;
  logic [CNT_W-1:0] count_reg;
  logic             strobe_reg;
  logic             load_valid_reg;
  logic             full;

  keypad_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .data_val_n(data_val_n),
    .accept    (accept),
    .code      (accept_code)
  );

  // New digit enters the low nibble; every older digit moves up one slot.
  assign shifted[BCD_W-1:0] = accept_code;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_shift
      assign shifted[gi*BCD_W +: BCD_W] = digits_reg[(gi-1)*BCD_W +: BCD_W];
    end
  endgenerate

  assign full = (count_reg == CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_reg     <= '0;
      count_reg      <= '0;
      strobe_reg     <= 1'b0;
      load_valid_reg <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (load_valid_reg) begin
        // Entry is frozen while offered; only the consumer's ready can release it.
        if (load_ready) begin
          load_valid_reg <= 1'b0;
          digits_reg     <= '0;
          count_reg      <= '0;
        end
      end else if (clear) begin
        digits_reg <= '0;
        count_reg  <= '0;
      end else if (start && (count_reg != '0)) begin
        load_valid_reg <= 1'b1;
      end else if (accept) begin
        strobe_reg <= 1'b1;
        if (!full) begin
          digits_reg <= shifted;
          count_reg  <= count_reg + CNT_W'(1);
        end else begin
`ifdef KEYPAD_ROLLOVER_EN
          digits_reg <= shifted;
`else
          digits_reg <= digits_reg;
`endif
        end
      end
    end
  end

  assign digits_out  = digits_reg;
  assign digit_count = count_reg;
  assign key_strobe  = strobe_reg;
  assign load_valid  = load_valid_reg;

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Directed self-checking bench for keypad_digit_loader (NUM_DIGITS=4, DEBOUNCE_CYCLES=4).
module tb_keypad_digit_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bcd_in;
  logic        data_val_n;
  logic        clear;
  logic        start;
  logic        load_ready;
  logic [15:0] digits_out;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic        load_valid;

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  logic [15:0] exp_full;

  keypad_digit_loader #(
    .NUM_DIGITS     (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .data_val_n (data_val_n),
    .clear      (clear),
    .start      (start),
    .load_ready (load_ready),
    .digits_out (digits_out),
    .digit_count(digit_count),
    .key_strobe (key_strobe),
    .load_valid (load_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_strobe === 1'b1) strobe_cnt++;
  endtask

  task automatic press(input logic [3:0] code);
    bcd_in = code;
    data_val_n = 1'b0;
    repeat (6) tick();
    data_val_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bcd_in = 4'd0; data_val_n = 1'b1;
    clear = 1'b0; start = 1'b0; load_ready = 1'b0;
    #12;
    check("rst_digits", 32'(digits_out), 32'h0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_strobe", 32'(key_strobe), 32'd0);
    check("rst_lvalid", 32'(load_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: steady press of 5, strobe exactly 4 cycles after first sample
    strobe_cnt = 0;
    bcd_in = 4'd5; data_val_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) check("t1_early", 32'(key_strobe), 32'd0);
      if (i == 5) check("t1_strobe", 32'(key_strobe), 32'd1);
    end
    data_val_n = 1'b1;
    repeat (8) tick();
    check("t1_nstrobe", 32'(strobe_cnt), 32'd1);
    check("t1_digits", 32'(digits_out), 32'h0005);
    check("t1_count", 32'(digit_count), 32'd1);
    pulse_clear();
    check("clr_digits", 32'(digits_out), 32'h0);

    // 2: bouncing valid flag, then code change mid-debounce, then invalid code
    strobe_cnt = 0;
    bcd_in = 4'd3;
    data_val_n = 1'b0; tick();
    data_val_n = 1'b1; tick();
    data_val_n = 1'b0; tick();
    data_val_n = 1'b1; tick();
    data_val_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) check("t2_early", 32'(key_strobe), 32'd0);
      if (i == 5) check("t2_strobe", 32'(key_strobe), 32'd1);
    end
    data_val_n = 1'b1;
    repeat (8) tick();
    check("t2_nstrobe", 32'(strobe_cnt), 32'd1);
    check("t2_digits", 32'(digits_out), 32'h0003);
    bcd_in = 4'd3; data_val_n = 1'b0;
    repeat (2) tick();
    bcd_in = 4'd7;
    repeat (8) tick();
    data_val_n = 1'b1;
    repeat (8) tick();
    check("t2_chg_n", 32'(strobe_cnt), 32'd2);
    check("t2_chg_dig", 32'(digits_out), 32'h0037);
    check("t2_chg_cnt", 32'(digit_count), 32'd2);
    bcd_in = 4'd12; data_val_n = 1'b0;
    repeat (8) tick();
    data_val_n = 1'b1;
    repeat (4) tick();
    check("t2_badcode", 32'(strobe_cnt), 32'd2);

    // 3: five digits into a four-digit register
    pulse_clear();
    strobe_cnt = 0;
    for (int d = 1; d <= 5; d++) press(4'(d));
`ifdef KEYPAD_ROLLOVER_EN
    exp_full = 16'h2345;
`else
    exp_full = 16'h1234;
`endif
    check("t3_digits", 32'(digits_out), 32'(exp_full));
    check("t3_count", 32'(digit_count), 32'd4);
    check("t3_nstrobe", 32'(strobe_cnt), 32'd5);

    // 4: hand-off; entry frozen while offered
    pulse_clear();
    press(4'd1);
    press(4'd2);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_lvalid", 32'(load_valid), 32'd1);
    check("t4_digits", 32'(digits_out), 32'h0012);
    strobe_cnt = 0;
    press(4'd9);
    pulse_clear();
    check("t4_nostrobe", 32'(strobe_cnt), 32'd0);
    check("t4_frozen", 32'(digits_out), 32'h0012);
    check("t4_cnt_hold", 32'(digit_count), 32'd2);
    check("t4_lv_hold", 32'(load_valid), 32'd1);
    load_ready = 1'b1; tick(); load_ready = 1'b0;
    check("t4_lv_done", 32'(load_valid), 32'd0);
    check("t4_dig_done", 32'(digits_out), 32'h0);
    check("t4_cnt_done", 32'(digit_count), 32'd0);

    // 5: clear vs accept, start at zero, start vs accept
    press(4'd1);
    strobe_cnt = 0;
    bcd_in = 4'd4; data_val_n = 1'b0;
    repeat (4) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    check("t5_strobe", 32'(key_strobe), 32'd0);
    check("t5_digits", 32'(digits_out), 32'h0);
    data_val_n = 1'b1;
    repeat (8) tick();
    check("t5_nstrobe", 32'(strobe_cnt), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_start0", 32'(load_valid), 32'd0);
    press(4'd6);
    bcd_in = 4'd8; data_val_n = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    check("t5_st_lv", 32'(load_valid), 32'd1);
    check("t5_st_dig", 32'(digits_out), 32'h0006);
    check("t5_st_strb", 32'(key_strobe), 32'd0);
    data_val_n = 1'b1;
    repeat (8) tick();
    load_ready = 1'b1; tick(); load_ready = 1'b0;

    // 6: asynchronous reset mid-press and mid-handshake
    press(4'd2);
    bcd_in = 4'd5; data_val_n = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dig", 32'(digits_out), 32'h0);
    check("t6_rst_cnt", 32'(digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    strobe_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 4) check("t6_early", 32'(key_strobe), 32'd0);
      if (i == 5) check("t6_strobe", 32'(key_strobe), 32'd1);
    end
    data_val_n = 1'b1;
    repeat (8) tick();
    check("t6_digits", 32'(digits_out), 32'h0005);
    start = 1'b1; tick(); start = 1'b0;
    check("t6_lvalid", 32'(load_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_lv", 32'(load_valid), 32'd0);
    check("t6_rst_dig2", 32'(digits_out), 32'h0);
    check("t6_rst_cnt2", 32'(digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
